// File: rtl/qmac.sv
// rtl/qmac.sv - streaming saturating Q-format multiply-accumulate with one frame sum per in_last
// Optional build macro QMAC_ROUND_EN selects round-half-up products instead of floor truncation.
module qmac #(
  parameter int Q = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_sat
);

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_MAX = 32'h8000_0000;

  state_t      state;
  logic        s1_valid;
  logic [31:0] s1_p;
  logic        s1_last;
  logic        s1_sat;
  logic [31:0] acc;
  logic        frame_sat;

  logic               accept;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod_full;
  logic signed [63:0] prod_adj;
  logic signed [63:0] prod_shift;
  logic               prod_ovf;
  logic [31:0]        prod_val;
  logic [32:0]        add_res;

  function automatic logic [32:0] sat_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] s;
    s = x + y;
    if ((x[31] == y[31]) && (s[31] != x[31]))
      return {1'b1, (x[31] ? NEG_MAX : POS_MAX)};
    return {1'b0, s};
  endfunction

  assign accept = in_valid && in_ready;

  assign a_ext     = {{32{in_a[31]}}, in_a};
  assign b_ext     = {{32{in_b[31]}}, in_b};
  assign prod_full = a_ext * b_ext;
`ifdef QMAC_ROUND_EN
  assign prod_adj  = prod_full + (64'sd1 <<< (Q - 1));
`else
  assign prod_adj  = prod_full;
`endif
  assign prod_shift = prod_adj >>> Q;
  // Anything outside 32-bit signed range shows up as non-sign bits above bit 31.
  assign prod_ovf   = (prod_shift[63:31] != {33{prod_shift[31]}});
  assign prod_val   = prod_ovf ? (prod_shift[63] ? NEG_MAX : POS_MAX) : prod_shift[31:0];

  assign add_res = sat_add(acc, s1_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      in_ready  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_p      <= 32'h0;
      s1_last   <= 1'b0;
      s1_sat    <= 1'b0;
      acc       <= 32'h0;
      frame_sat <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= 32'h0;
      out_sat   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_p    <= prod_val;
        s1_last <= in_last;
        s1_sat  <= prod_ovf;
      end

      if (s1_valid) begin
        acc       <= add_res[31:0];
        frame_sat <= frame_sat | s1_sat | add_res[32];
      end

      case (state)
        RUN: begin
          // in_ready drops right after the last beat; FLUSH starts once it has reached stage 2.
          if (s1_valid && s1_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end else begin
            in_ready <= !(accept && in_last);
          end
        end
        FLUSH: begin
          out_sum   <= acc;
          out_sat   <= frame_sat;
          out_valid <= 1'b1;
          acc       <= 32'h0;
          frame_sat <= 1'b0;
          in_ready  <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= RUN;
          end
        end
        default: begin
          state    <= RUN;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmac.sv
// tb/tb_qmac.sv - directed table plus randomized frames checked against an arithmetic model of qmac
// Expected rounding results follow QMAC_ROUND_EN when the bench is built with it.
module tb_qmac;
  localparam int Q = 15;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qmac #(.Q(Q)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat)
  );

  typedef struct {
    string            name;
    int               n;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [31:0]      sum;
    logic             sat;
    int               delay;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef QMAC_ROUND_EN
    p = p + (longint'(1) <<< (Q - 1));
`endif
    p = p >>> Q;
    if (p > MAXV) return {1'b1, 32'h7FFF_FFFF};
    if (p < MINV) return {1'b1, 32'h8000_0000};
    return {1'b0, p[31:0]};
  endfunction

  function automatic logic [32:0] model_frame(input int n, input logic [7:0][31:0] a,
                                              input logic [7:0][31:0] b);
    longint s = 0;
    logic   sat = 1'b0;
    logic [32:0] r;
    for (int i = 0; i < n; i++) begin
      r = model_prod(a[i], b[i]);
      sat |= r[32];
      s = s + longint'($signed(r[31:0]));
      if (s > MAXV) begin s = MAXV; sat = 1'b1; end
      else if (s < MINV) begin s = MINV; sat = 1'b1; end
    end
    return {sat, s[31:0]};
  endfunction

  function automatic vec_t mk(input string name, input int n,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] a2, input logic [31:0] b2,
                              input logic [31:0] sum, input logic sat, input int delay);
    vec_t v;
    v.name = name; v.n = n; v.a = '0; v.b = '0;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
    v.sum = sum; v.sat = sat; v.delay = delay;
    return v;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 131072)) - 32'd65536;
      2: begin
        case ($urandom_range(0, 3))
          0: v = 32'h7FFF_FFFF;
          1: v = 32'h8000_0000;
          2: v = 32'h4000_0000;
          default: v = 32'hC000_0000;
        endcase
      end
      default: v = $urandom_range(0, 1) ? 32'h0000_8000 : 32'hFFFF_8000;
    endcase
    return v;
  endfunction

  task automatic run_frame(input string name, input int n, input logic [7:0][31:0] a,
                           input logic [7:0][31:0] b, input logic [31:0] exp_sum,
                           input logic exp_sat, input int delay, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) step;
      end
      in_valid = 1'b1;
      in_a = a[i];
      in_b = b[i];
      in_last = (i == n - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        step;
        w++;
      end
      if (w >= 50) begin
        checks++;
        failures++;
        $display("FAIL %s_in_ready_timeout actual=0 required=1", name);
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      step;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    step;
    check($sformatf("%s_lat1_valid", name), 32'(out_valid), 32'd0);
    step;
    check($sformatf("%s_lat2_valid", name), 32'(out_valid), 32'd1);
    for (int d = 0; d < delay; d++) begin
      check($sformatf("%s_bp_sum%0d", name, d), out_sum, exp_sum);
      check($sformatf("%s_bp_sat%0d", name, d), 32'(out_sat), 32'(exp_sat));
      check($sformatf("%s_bp_ready%0d", name, d), 32'(in_ready), 32'd0);
      step;
    end
    check($sformatf("%s_sum", name), out_sum, exp_sum);
    check($sformatf("%s_sat", name), 32'(out_sat), 32'(exp_sat));
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check($sformatf("%s_post_valid", name), 32'(out_valid), 32'd0);
    check($sformatf("%s_post_ready", name), 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] ra;
    logic [7:0][31:0] rb;
    logic [32:0]      exp;
    int               n;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    step;
    step;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum", out_sum, 32'd0);
    check("reset_out_sat", 32'(out_sat), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step;

    tbl[0] = mk("frame3", 3, 32'h8000, 32'h8000, 32'h4000, 32'h8000, 32'h4000, 32'h4000,
                32'h0000_E000, 1'b0, 0);
    tbl[1] = mk("prod_sat", 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 0, 32'h7FFF_FFFF, 1'b1, 0);
    tbl[2] = mk("acc_ovf", 2, 32'h4000_0000, 32'h8000, 32'h4000_0000, 32'h8000, 0, 0,
                32'h7FFF_FFFF, 1'b1, 0);
    tbl[3] = mk("acc_unf", 3, 32'hC000_0000, 32'h8000, 32'hC000_0000, 32'h8000,
                32'hC000_0000, 32'h8000, 32'h8000_0000, 1'b1, 0);
    tbl[4] = mk("backpressure", 3, 32'h8000, 32'h8000, 32'h4000, 32'h8000, 32'h4000, 32'h4000,
                32'h0000_E000, 1'b0, 5);
    tbl[5] = mk("after_bp", 1, 32'h8000, 32'h8000, 0, 0, 0, 0, 32'h0000_8000, 1'b0, 0);
    tbl[6] = mk("sticky", 3, 32'h4000_0000, 32'h8000, 32'h4000_0000, 32'h8000,
                32'hC000_0000, 32'h8000, 32'h3FFF_FFFF, 1'b1, 0);
`ifdef QMAC_ROUND_EN
    tbl[7] = mk("round_pos", 1, 32'h1, 32'h4000, 0, 0, 0, 0, 32'h0000_0001, 1'b0, 0);
    tbl[8] = mk("round_neg", 1, 32'hFFFF_FFFF, 32'h4000, 0, 0, 0, 0, 32'h0000_0000, 1'b0, 0);
`else
    tbl[7] = mk("round_pos", 1, 32'h1, 32'h4000, 0, 0, 0, 0, 32'h0000_0000, 1'b0, 0);
    tbl[8] = mk("round_neg", 1, 32'hFFFF_FFFF, 32'h4000, 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 0);
`endif

    for (int i = 0; i < 9; i++)
      run_frame(tbl[i].name, tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].sat,
                tbl[i].delay, 1'b0);

    // Two non-last beats, then a one-cycle reset discards the partial frame.
    in_valid = 1'b1; in_a = 32'h7FFF_0000; in_b = 32'h7FFF_0000; in_last = 1'b0;
    step;
    step;
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("midrst_no_valid%0d", i), 32'(out_valid), 32'd0);
      step;
    end
    ra = '0; rb = '0;
    ra[0] = 32'h8000; rb[0] = 32'h4000;
    run_frame("after_rst", 1, ra, rb, 32'h0000_4000, 1'b0, 0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 8);
      ra = '0; rb = '0;
      for (int i = 0; i < n; i++) begin
        ra[i] = rnd_op();
        rb[i] = rnd_op();
      end
      exp = model_frame(n, ra, rb);
      run_frame($sformatf("rnd%0d", f), n, ra, rb, exp[31:0], exp[32],
                $urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 1) == 1) step;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
